// File: rtl/sensor_readout_arbiter_if.sv
// Sensor-side request/row signals and pixel output bus of the sensor readout arbiter.
// master: the arbiter; slave: the sensors plus downstream consumer.
interface sensor_readout_arbiter_if #(
  parameter int NUM_SENSORS = 2,
  parameter int PIXEL_BITS  = 8,
  parameter int ROW_PIXELS  = 4
);
  localparam int SENSOR_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int COL_W    = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;

  logic [NUM_SENSORS-1:0]                       row_req;
  logic [NUM_SENSORS*ROW_PIXELS*PIXEL_BITS-1:0] row_data;
  logic [NUM_SENSORS-1:0]                       row_ack;
  logic                                         bus_valid;
  logic                                         bus_ready;
  logic [PIXEL_BITS-1:0]                        bus_data;
  logic [SENSOR_W-1:0]                          bus_sensor;
  logic [COL_W-1:0]                             bus_col;
  logic                                         bus_last;
  logic [NUM_SENSORS-1:0]                       overrun;

  modport master (
    input  row_req, row_data, bus_ready,
    output row_ack, bus_valid, bus_data, bus_sensor, bus_col, bus_last, overrun
  );

  modport slave (
    output row_req, row_data, bus_ready,
    input  row_ack, bus_valid, bus_data, bus_sensor, bus_col, bus_last, overrun
  );
endinterface

// File: rtl/sensor_readout_arbiter.sv
// Round-robin arbiter that latches one sensor row and streams it pixel by pixel.
// Optional per-sensor wait/overrun monitor enabled by defining SENSOR_ARB_OVERRUN_EN.
module sensor_readout_arbiter #(
  parameter int NUM_SENSORS = 2,
  parameter int PIXEL_BITS  = 8,
  parameter int ROW_PIXELS  = 4,
  parameter int MAX_WAIT    = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  sensor_readout_arbiter_if.master       bus
);
  localparam int SENSOR_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int COL_W    = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam int ROW_BITS = ROW_PIXELS * PIXEL_BITS;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_PIXELS - 1);

  if (NUM_SENSORS < 2 || MAX_WAIT < 1) begin : g_param_check
    $error("sensor_readout_arbiter: NUM_SENSORS must be >= 2 and MAX_WAIT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SENSOR_W-1:0]   ptr_q, ptr_d;
  logic [SENSOR_W-1:0]   grant_q, grant_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;

  logic [ROW_BITS-1:0]   row_slice [NUM_SENSORS];
  logic [PIXEL_BITS-1:0] row_pix   [ROW_PIXELS];
  logic [SENSOR_W-1:0]   rr_pick;
  logic                  rr_found;
  int                    rr_dist;
  int                    rr_best;
  logic [NUM_SENSORS-1:0] ack;
  logic                  valid;

  genvar gi;
  for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_slice
    assign row_slice[gi] = bus.row_data[gi*ROW_BITS +: ROW_BITS];
  end
  for (gi = 0; gi < ROW_PIXELS; gi++) begin : g_pix
    assign row_pix[gi] = row_q[gi*PIXEL_BITS +: PIXEL_BITS];
  end

  // Pick the requester closest to pointer+1 going upward with wrap-around.
  always_comb begin
    rr_pick  = '0;
    rr_best  = NUM_SENSORS;
    rr_dist  = 0;
    rr_found = |bus.row_req;
    for (int s = 0; s < NUM_SENSORS; s++) begin
      rr_dist = (s + 2*NUM_SENSORS - int'(ptr_q) - 1) % NUM_SENSORS;
      if (bus.row_req[s] && rr_dist < rr_best) begin
        rr_best = rr_dist;
        rr_pick = SENSOR_W'(s);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        row_d   = row_slice[grant_q];
        ptr_d   = grant_q;
        col_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bus.bus_ready) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = ST_IDLE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= SENSOR_W'(NUM_SENSORS - 1);
      grant_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Bus fields are forced to zero outside SHIFT so idle/reset outputs read as 0.
  assign valid          = (state_q == ST_SHIFT);
  assign ack            = (state_q == ST_LATCH) ? (NUM_SENSORS'(1) << grant_q) : '0;
  assign bus.row_ack    = ack;
  assign bus.bus_valid  = valid;
  assign bus.bus_data   = valid ? row_pix[col_q] : '0;
  assign bus.bus_sensor = valid ? grant_q : '0;
  assign bus.bus_col    = valid ? col_q : '0;
  assign bus.bus_last   = valid && (col_q == LAST_COL);

`ifdef SENSOR_ARB_OVERRUN_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  for (gi = 0; gi < NUM_SENSORS; gi++) begin : g_wait
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ovr_q, ovr_d;

    always_comb begin
      wait_d = wait_q;
      if (ack[gi]) begin
        wait_d = '0;
      end else if (bus.row_req[gi] && wait_q != WAIT_W'(MAX_WAIT)) begin
        wait_d = wait_q + WAIT_W'(1);
      end
      ovr_d = ovr_q | (wait_d == WAIT_W'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_q <= '0;
        ovr_q  <= 1'b0;
      end else begin
        wait_q <= wait_d;
        ovr_q  <= ovr_d;
      end
    end

    assign bus.overrun[gi] = ovr_q;
  end
`else
  assign bus.overrun = '0;
`endif
endmodule

// File: tb/tb_sensor_readout_arbiter.sv
// Self-checking bench: queue-based row/beat model compared every cycle, plus directed literal checks.
// Overrun checks are active when SENSOR_ARB_OVERRUN_EN is defined.
module tb_sensor_readout_arbiter;
  localparam int N  = 2;
  localparam int PB = 8;
  localparam int RP = 4;
  localparam int MW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sensor_readout_arbiter_if #(.NUM_SENSORS(N), .PIXEL_BITS(PB), .ROW_PIXELS(RP)) bif ();

  sensor_readout_arbiter #(
    .NUM_SENSORS(N), .PIXEL_BITS(PB), .ROW_PIXELS(RP), .MAX_WAIT(MW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [PB-1:0] data;
    int            sensor;
    int            col;
    logic          last;
  } beat_t;

  beat_t          m_q[$];
  logic [N-1:0]   m_ack = '0;
  int             m_ptr = N - 1;
  int             m_g   = 0;
  int             m_cnt[N];
  logic [N-1:0]   m_ov  = '0;

  task automatic model_step();
    logic          idle;
    logic [63:0]   rd;
    logic [63:0]   sh;
    beat_t         b;
    if (!rst_n) begin
      m_q.delete();
      m_ack = '0;
      m_ptr = N - 1;
      m_g   = 0;
      m_ov  = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    idle = (m_q.size() == 0) && (m_ack == '0);
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) m_cnt[i] = 0;
      else if (bif.row_req[i] && m_cnt[i] < MW) m_cnt[i]++;
      if (m_cnt[i] == MW) m_ov[i] = 1'b1;
    end
    if (m_q.size() > 0 && bif.bus_ready) void'(m_q.pop_front());
    if (m_ack != '0) begin
      rd = bif.row_data;
      for (int c = 0; c < RP; c++) begin
        sh       = rd >> ((m_g * RP + c) * PB);
        b.data   = sh[PB-1:0];
        b.sensor = m_g;
        b.col    = c;
        b.last   = (c == RP - 1);
        m_q.push_back(b);
      end
      m_ack = '0;
    end else if (idle && bif.row_req != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (bif.row_req[(m_ptr + k) % N]) begin
          m_g = (m_ptr + k) % N;
          break;
        end
      end
      m_ack = '0;
      m_ack[m_g] = 1'b1;
      m_ptr = m_g;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("ack", bif.row_ack, m_ack);
      chk("valid", bif.bus_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("data", bif.bus_data, m_q[0].data);
        chk("sensor", bif.bus_sensor, m_q[0].sensor);
        chk("col", bif.bus_col, m_q[0].col);
        chk("last", bif.bus_last, m_q[0].last);
      end
`ifdef SENSOR_ARB_OVERRUN_EN
      chk("overrun", bif.overrun, m_ov);
`else
      chk("overrun_off", bif.overrun, '0);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bif.bus_valid || bif.row_ack != '0) && n < 50) begin
      tick();
      n++;
    end
    chk("idle_reached", n < 50, 1'b1);
  endtask

  logic [63:0] rd0;
  int          seen[4];
  int          nseen, ack_cycles, ack_run, ack_run_max;
  logic        saw_ack0;
  logic [N-1:0] ackv;

  initial begin
    bif.row_req   = '0;
    bif.row_data  = '0;
    bif.bus_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", bif.bus_valid, 1'b0);
    chk("rst_ack", bif.row_ack, '0);
    chk("rst_data", bif.bus_data, '0);
    chk("rst_last", bif.bus_last, 1'b0);
    chk("rst_overrun", bif.overrun, '0);
    rst_n = 1'b1;
    tick();

    // Single row from sensor 0 with exact beat timing.
    bif.bus_ready = 1'b1;
    bif.row_data  = {32'hA5A5A5A5, 32'h44332211};
    bif.row_req   = 2'b01;
    tick();
    chk("t2_ack", bif.row_ack, 2'b01);
    chk("t2_valid_latch", bif.bus_valid, 1'b0);
    bif.row_req = 2'b00;
    for (int c = 0; c < RP; c++) begin
      tick();
      if (c == 0) bif.row_data = 64'hDEADBEEF_CAFEF00D;
      chk("t2_valid", bif.bus_valid, 1'b1);
      chk("t2_data", bif.bus_data, 8'h11 * (c + 1));
      chk("t2_col", bif.bus_col, c);
      chk("t2_last", bif.bus_last, c == RP - 1);
    end
    tick();
    chk("t2_valid_drop", bif.bus_valid, 1'b0);

    // Reset in the middle of a row at column 2.
    bif.row_req = 2'b01;
    tick();
    bif.row_req = 2'b00;
    repeat (3) tick();
    chk("t1_col2", bif.bus_col, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", bif.bus_valid, 1'b0);
    chk("t1_data", bif.bus_data, '0);
    chk("t1_col", bif.bus_col, '0);
    chk("t1_last", bif.bus_last, 1'b0);
    chk("t1_ack", bif.row_ack, '0);
    tick();
    rst_n = 1'b1;
    tick();
    bif.row_req = 2'b10;
    tick();
    chk("t1_ack1", bif.row_ack, 2'b10);
    bif.row_req = 2'b00;
    wait_idle();

    // Both sensors requesting continuously: strict alternation.
    nseen = 0; ack_cycles = 0; ack_run = 0; ack_run_max = 0;
    bif.row_req = 2'b11;
    for (int i = 0; i < 60 && nseen < 4; i++) begin
      tick();
      if (bif.row_ack != '0) begin
        ack_cycles++;
        ack_run++;
        if (ack_run > ack_run_max) ack_run_max = ack_run;
      end else begin
        ack_run = 0;
      end
      if (bif.bus_valid && bif.bus_col == 0) begin
        seen[nseen] = int'(bif.bus_sensor);
        nseen++;
        if (nseen == 4) bif.row_req = 2'b00;
      end
    end
    chk("t3_rows", nseen, 4);
    for (int k = 0; k < 4; k++) chk("t3_order", seen[k], k % 2);
    chk("t3_ack_cycles", ack_cycles, 4);
    chk("t3_ack_width", ack_run_max, 1);
    wait_idle();

    // Back-pressure on column 1.
    rd0 = {32'h0, 32'h9C7B5A39};
    bif.row_data = rd0;
    bif.row_req  = 2'b01;
    tick();
    bif.row_req = 2'b00;
    tick();
    tick();
    bif.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_valid", bif.bus_valid, 1'b1);
      chk("t4_col", bif.bus_col, 1);
      chk("t4_data", bif.bus_data, rd0[15:8]);
      chk("t4_sensor", bif.bus_sensor, 0);
    end
    bif.bus_ready = 1'b1;
    tick();
    chk("t4_col_next", bif.bus_col, 2);
    chk("t4_data_next", bif.bus_data, rd0[23:16]);
    wait_idle();

    // A one-cycle request during SHIFT must never be granted.
    bif.row_req = 2'b10;
    tick();
    bif.row_req = 2'b00;
    tick();
    tick();
    bif.row_req = 2'b01;
    tick();
    bif.row_req = 2'b00;
    saw_ack0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_ack0 = saw_ack0 | bif.row_ack[0];
    end
    chk("t5_no_ack0", saw_ack0, 1'b0);

`ifdef SENSOR_ARB_OVERRUN_EN
    // Sensor 1 starves while sensor 0's row is stalled.
    bif.bus_ready = 1'b0;
    bif.row_req   = 2'b01;
    tick();
    bif.row_req = 2'b10;
    for (int i = 1; i <= MW; i++) begin
      tick();
      if (i == MW - 1) chk("t6_ovr_before", bif.overrun[1], 1'b0);
      if (i == MW)     chk("t6_ovr_set", bif.overrun[1], 1'b1);
    end
    bif.bus_ready = 1'b1;
    ackv = '0;
    for (int i = 0; i < 20 && !ackv[1]; i++) begin
      tick();
      ackv = bif.row_ack;
    end
    chk("t6_granted", ackv[1], 1'b1);
    bif.row_req = 2'b00;
    wait_idle();
    chk("t6_ovr_sticky", bif.overrun[1], 1'b1);
`endif

    // Randomized traffic against the model, with one asynchronous reset pulse.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ackv = bif.row_ack;
      for (int i = 0; i < N; i++) begin
        if (bif.row_req[i] && ackv[i])      bif.row_req[i] = ($urandom % 2) == 0;
        else if (bif.row_req[i])            bif.row_req[i] = ($urandom % 32) != 0;
        else                                bif.row_req[i] = ($urandom % 3) == 0;
      end
      bif.row_data  = {$urandom, $urandom};
      bif.bus_ready = ($urandom % 4) != 0;
      if (cyc == 1500) begin
        #3 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
